// File: rtl/ws2812_strip_driver_if.sv
// Write port into the WS2812 frame buffer.
// The pattern logic is the master; the strip driver is the slave.
interface ws2812_strip_driver_if;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        write;

    modport master (output rgb_data, output led_num, output write);
    modport slave  (input rgb_data, input led_num, input write);
endinterface

// File: rtl/ws2812_strip_driver.sv
// WS2812 chain driver: frame buffer plus single-wire serializer.
// Refreshes the strip continuously with a latch gap between frames.
module ws2812_strip_driver #(
    parameter int NUM_LEDS = 50,
    parameter int T_BIT    = 15,
    parameter int T0H      = 4,
    parameter int T1H      = 9,
    parameter int T_LATCH  = 840
) (
    input  logic                        clk,
    input  logic                        reset,
    ws2812_strip_driver_if.slave        wr,
    output logic                        data,
    output logic                        frame_done
);
    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam int LW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;

    localparam logic [7:0]    LAST_NUM = 8'(NUM_LEDS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
    localparam logic [BW-1:0] LAST_B   = BW'(T_BIT - 1);
    localparam logic [LW-1:0] LAST_L   = LW'(T_LATCH - 1);
    localparam logic [BW-1:0] H0       = BW'(T0H);
    localparam logic [BW-1:0] H1       = BW'(T1H);

    typedef enum logic [1:0] {LATCH, LOAD, SEND} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [4:0]    bidx_q, bidx_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [23:0]   shift_q, shift_d;
    logic          data_d, done_d;
    logic [23:0]   rd_word;

    // Contents survive reset so a restarted frame resends the stored colours.
    logic [23:0] frame_buf [NUM_LEDS] = '{default: 24'h0};

    always_ff @(posedge clk) begin
        if (wr.write && (wr.led_num <= LAST_NUM))
            frame_buf[wr.led_num[IW-1:0]] <= wr.rgb_data;
    end

    assign rd_word = frame_buf[idx_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LATCH;
            lcnt_q     <= '0;
            bcnt_q     <= '0;
            bidx_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            lcnt_q     <= lcnt_d;
            bcnt_q     <= bcnt_d;
            bidx_q     <= bidx_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data       <= data_d;
            frame_done <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = '0;
        bcnt_d  = '0;
        bidx_d  = bidx_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            LATCH: begin
                lcnt_d = lcnt_q + 1'b1;
                if (lcnt_q == LAST_L) begin
                    lcnt_d  = '0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Wire order is G, R, B, each MSB first.
                shift_d = {rd_word[15:8], rd_word[23:16], rd_word[7:0]};
                bidx_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                data_d = bcnt_q < (shift_q[23] ? H1 : H0);
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == LAST_B) begin
                    bcnt_d  = '0;
                    shift_d = shift_q << 1;
                    bidx_d  = bidx_q + 1'b1;
                    if (bidx_q == 5'd23) begin
                        bidx_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = LATCH;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LOAD;
                        end
                    end
                end
            end
            default: state_d = LATCH;
        endcase
    end
endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Bench for ws2812_strip_driver: decodes the wire into 24-bit words
// and compares them against colours queued as writes are driven.
module tb_ws2812_strip_driver;
    localparam int NUM_LEDS = 50;
    localparam int T_BIT    = 15;
    localparam int T0H      = 4;
    localparam int T1H      = 9;
    localparam int T_LATCH  = 840;
    localparam int PERIOD   = T_LATCH + NUM_LEDS * (1 + 24 * T_BIT);
    localparam int BOUND    = 40000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic data;
    logic frame_done;

    ws2812_strip_driver_if bus ();

    ws2812_strip_driver #(
        .NUM_LEDS(NUM_LEDS),
        .T_BIT   (T_BIT),
        .T0H     (T0H),
        .T1H     (T1H),
        .T_LATCH (T_LATCH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (bus),
        .data      (data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_q [$];
    logic [23:0] model [NUM_LEDS];

    int since_rise = 0;
    int since_fd   = 0;
    int cyc_rst    = 0;
    int leds       = 0;
    int nbits      = 0;
    int hi         = 0;
    int fd_seen    = 0;
    bit prev       = 1'b0;
    bit bad        = 1'b0;
    bit first_fd   = 1'b1;
    logic [23:0] word = '0;
    logic [23:0] expw;

    function automatic logic [23:0] to_wire(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

    // Wire decoder and scoreboard checker.
    always @(negedge clk) begin
        if (reset) begin
            first_fd = 1'b1;
            cyc_rst  = 0;
            leds     = 0;
            nbits    = 0;
            hi       = 0;
            prev     = 1'b0;
            bad      = 1'b0;
            exp_q.delete();
        end else begin
            cyc_rst++;
            since_rise++;
            since_fd++;
            if (data && !prev) begin
                if (nbits == 0 && leds == 0)
                    bad = bad | (since_fd != 2);
                else if (nbits == 0)
                    bad = bad | (since_rise != T_BIT + 1);
                else
                    bad = bad | (since_rise != T_BIT);
                since_rise = 0;
                hi = 0;
            end
            if (data)
                hi++;
            if (!data && prev) begin
                if (hi != T0H && hi != T1H)
                    bad = 1'b1;
                word = {word[22:0], (hi == T1H)};
                nbits++;
                if (nbits == 24) begin
                    expw = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
                    checks++;
                    assert ({bad, word} === {1'b0, expw}) else begin
                        errors++;
                        $error("FAIL led%0d_word: observed=%h bad_timing=%0d expected=%h",
                               leds, word, bad, expw);
                    end
                    leds++;
                    nbits = 0;
                    bad   = 1'b0;
                end
            end
            if (frame_done) begin
                checks++;
                if (first_fd) begin
                    assert (cyc_rst == T_LATCH) else begin
                        errors++;
                        $error("FAIL first_frame_done: observed=%0d expected=%0d",
                               cyc_rst, T_LATCH);
                    end
                end else begin
                    assert (since_fd == PERIOD && leds == NUM_LEDS &&
                            since_rise == T_BIT + T_LATCH - 1) else begin
                        errors++;
                        $error("FAIL frame_period: observed=%0d/%0d/%0d expected=%0d/%0d/%0d",
                               since_fd, leds, since_rise,
                               PERIOD, NUM_LEDS, T_BIT + T_LATCH - 1);
                    end
                end
                first_fd = 1'b0;
                since_fd = 0;
                leds     = 0;
                nbits    = 0;
                bad      = 1'b0;
                fd_seen++;
            end
            prev = data;
        end
    end

    task automatic bail(input string tag);
        errors++;
        checks++;
        $display("FAIL %s: observed=timeout expected=event", tag);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic wait_fd(input int n);
        int i;
        for (i = 0; i < BOUND && fd_seen < n; i++) begin
            @(negedge clk);
            #1;
        end
        if (fd_seen < n)
            bail("wait_frame_done");
    endtask

    task automatic wait_pos(input int l, input int b, input bit need_hi);
        int i;
        for (i = 0; i < BOUND; i++) begin
            if (leds == l && nbits >= b && (!need_hi || data))
                break;
            @(negedge clk);
            #1;
        end
        if (i >= BOUND)
            bail("wait_led_position");
    endtask

    task automatic do_write(input int idx, input logic [23:0] c);
        bus.led_num  = 8'(idx);
        bus.rgb_data = c;
        bus.write    = 1'b1;
        if (idx < NUM_LEDS)
            model[idx] = c;
        @(negedge clk);
        #1;
        bus.write = 1'b0;
    endtask

    task automatic push_range(input int lo, input int hi_idx);
        for (int i = lo; i <= hi_idx; i++)
            exp_q.push_back(to_wire(model[i]));
    endtask

    initial begin
        bus.write    = 1'b0;
        bus.led_num  = '0;
        bus.rgb_data = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            model[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        checks++;
        assert ({data, frame_done} === 2'b00) else begin
            errors++;
            $error("FAIL reset_outputs: observed=%b expected=00", {data, frame_done});
        end
        push_range(0, NUM_LEDS - 1);
        reset = 1'b0;

        // Empty frame, then writes during the following latch gap.
        wait_fd(1);
        wait_pos(NUM_LEDS, 0, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        do_write(0, 24'h10_20_30);
        do_write(1, 24'hAA_AA_AA);
        do_write(1, 24'h12_34_56);
        do_write(49, 24'h00_00_01);
        do_write(50, 24'hFF_FF_FF);
        do_write(255, 24'hFF_FF_FF);
        push_range(0, 5);

        // Mid-frame writes: one behind the serializer, one ahead of it.
        wait_fd(2);
        wait_pos(5, 0, 1'b0);
        do_write(3, 24'hFF_00_00);
        do_write(7, 24'hFF_00_00);
        push_range(6, NUM_LEDS - 1);
        push_range(0, NUM_LEDS - 1);

        // Reset while LED 10 bit 12 is high.
        wait_fd(3);
        wait_pos(10, 12, 1'b1);
        reset = 1'b1;
        #1;
        checks++;
        assert (data === 1'b0) else begin
            errors++;
            $error("FAIL async_reset_data: observed=%b expected=0", data);
        end
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        push_range(0, NUM_LEDS - 1);

        wait_fd(5);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drained: observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
